// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag index and driver state definitions
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_t;

    typedef enum int unsigned {
        FLG_OVF  = 0,
        FLG_NEG  = 1,
        FLG_ZERO = 2,
        FLG_COUT = 3,
        FLG_DIV0 = 4
    } alu_flag_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } drv_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous active-low clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - sequences one tagged ALU operation per command with done timeout
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [1:0]       alu_select,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [15:0]      alu_result,
    input  logic [4:0]       alu_flags,
    input  logic             alu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic             rsp_timeout,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_ops,
    output logic [CNT_W-1:0] cnt_timeouts
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    drv_state_t       state;
    drv_state_t       state_nxt;
    logic [TMR_W-1:0] timer;
    logic             accept;
    logic             rsp_fire;
    logic             timer_expired;

    assign accept        = cmd_valid && cmd_ready;
    assign rsp_fire      = rsp_valid && rsp_ready;
    assign timer_expired = (timer == TMR_LAST);
    assign busy          = (state != ST_IDLE);

    // State register; reset aborts any command in flight without a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus handshake outputs; IDLE only accepts once the previous done has cleared.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = !alu_done;
                if (cmd_valid && !alu_done) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (alu_done || timer_expired) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand/tag capture at accept, done timer, and response capture; done beats the timer limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_select  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp_tag     <= '0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b0;
            timer       <= '0;
        end else begin
            if (accept) begin
                alu_select <= cmd_op;
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                rsp_tag    <= cmd_tag;
            end
            if (state == ST_ISSUE) begin
                timer <= '0;
            end
            if (state == ST_WAIT_DONE) begin
                if (alu_done) begin
                    rsp_result  <= alu_result;
                    rsp_flags   <= alu_flags;
                    rsp_timeout <= 1'b0;
                end else if (timer_expired) begin
                    rsp_result  <= '0;
                    rsp_flags   <= '0;
                    rsp_timeout <= 1'b1;
                end else begin
                    timer <= timer + TMR_W'(1);
                end
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_cnt_ops (
        .clk   (clk),
        .rst_n (rst),
        .inc   (rsp_fire),
        .count (cnt_ops)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cnt_timeouts (
        .clk   (clk),
        .rst_n (rst),
        .inc   (rsp_fire && rsp_timeout),
        .count (cnt_timeouts)
    );

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Initiator side of the ALU operation handshake. It accepts tagged commands (opcode, A, B) on a valid/ready port, drives the ALU's select/A/B inputs, waits for the ALU's done, and captures result and flags. It returns a tagged response on a valid/ready port. It sits between the system command source and the alu instance, and replaces testbench-style wait(done) sequencing with synthesizable control.

Parameters:
TAG_W, 4, width of command/response tag
TIMEOUT_CYCLES, 64, max cycles in WAIT_DONE before aborting with timeout
CNT_W, 16, width of saturating statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  driver can accept command
cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
cmd_a  in  8  operand A
cmd_b  in  8  operand B
cmd_tag  in  TAG_W  opaque tag, returned with response
alu_select  out  2  to ALU select
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_result  in  16  from ALU result
alu_flags  in  5  {divisionBy0, carry_out, zero, negative, overflow} from ALU
alu_done  in  1  from ALU done
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  16  captured result; div: quotient [15:8], remainder [7:0]
rsp_flags  out  5  captured flags, same order as alu_flags
rsp_timeout  out  1  ALU failed to signal done in time
rsp_tag  out  TAG_W  tag of the command
busy  out  1  state != IDLE
cnt_ops  out  CNT_W  completed responses, saturating
cnt_timeouts  out  CNT_W  timed-out responses, saturating

Behaviour:
- Reset (rst=0, async): state IDLE. All registered outputs are 0: alu_*, rsp_*, busy, counters. cmd_ready follows IDLE rule below.
- States: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE: cmd_ready = 1 only when alu_done = 0. This guarantees the previous ALU done has cleared before a new issue. On cmd_valid && cmd_ready, register op/a/b/tag into alu_select/alu_a/alu_b and the tag register, then go to ISSUE.
- ISSUE: one settle cycle with operands stable. Clear timer. Go to WAIT_DONE.
- WAIT_DONE: alu_* held stable.
  - alu_done = 1: capture alu_result → rsp_result and alu_flags → rsp_flags; rsp_timeout = 0; go to RESP.
  - Otherwise the timer increments. When timer = TIMEOUT_CYCLES-1 without done: rsp_result = 0, rsp_flags = 0, rsp_timeout = 1; go to RESP.
  - done in the same cycle as the timer limit: done wins, no timeout.
- RESP: rsp_valid = 1. rsp_* held stable until rsp_ready. On the rsp_valid && rsp_ready cycle, go to IDLE, drop rsp_valid next cycle, increment cnt_ops, and increment cnt_timeouts if rsp_timeout.
- Minimum latency: accept at T, rsp_valid at T+3 if done is seen in the first WAIT_DONE cycle.
- One command in flight; no queuing; cmd_ready = 0 outside IDLE.
- Counters saturate at all-ones and never wrap.
- The driver passes divide-by-zero through unchanged (divisionBy0 flag). It performs no operand checking.
- Reset mid-operation: immediate abort to IDLE; no response is produced for the aborted command.
- Operands sampled only at accept; later changes on cmd_* are ignored.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11
  - flag bit indices FLG_OVF=0, FLG_NEG=1, FLG_ZERO=2, FLG_COUT=3, FLG_DIV0=4
  - driver state encoding
- One natural sub-module, sat_counter (param width, inc, async active-low clear), instantiated twice for the statistics counters.

Test Plan:
- add, A=15, B=8, immediate done model → rsp_result=23, flags=0, tag echoed, cnt_ops=1.
- sub 15-8, then mul 15*8, back-to-back → rsp_result 7 then 120. Second cmd_ready waits for alu_done low.
- div 15/8 → rsp_result=16'h0107. Then div 15/0 → rsp_flags[4]=1.
- ALU stub never asserts done → rsp_timeout=1 exactly 64 cycles after entering WAIT_DONE, rsp_result=0, cnt_timeouts=1.
- rsp_ready held low 10 cycles → rsp_* stable, cmd_ready=0, busy=1 throughout.
- rst low during WAIT_DONE → state IDLE, all outputs 0 asynchronously, no stale response after release.
